// File: rtl/base_rotr_pipe_if.sv
// base_rotr_pipe_if: input/output valid-ready handshakes of the rotator.
// i_dir exists only when BASE_ROTR_PIPE_LEFT_EN is defined.
interface base_rotr_pipe_if #(
    parameter int width = 8
);

    localparam int aw = (width > 1) ? $clog2(width) : 1;

    logic             i_v;
    logic             i_r;
    logic [0:width-1] i_d;
    logic [aw-1:0]    i_amt;
`ifdef BASE_ROTR_PIPE_LEFT_EN
    logic             i_dir;
`endif
    logic             o_v;
    logic             o_r;
    logic [0:width-1] o_d;

    modport slave (
`ifdef BASE_ROTR_PIPE_LEFT_EN
        input  i_dir,
`endif
        input  i_v,
        input  i_d,
        input  i_amt,
        input  o_r,
        output i_r,
        output o_v,
        output o_d
    );

    modport master (
`ifdef BASE_ROTR_PIPE_LEFT_EN
        output i_dir,
`endif
        output i_v,
        output i_d,
        output i_amt,
        output o_r,
        input  i_r,
        input  o_v,
        input  o_d
    );

endinterface

// File: rtl/base_rotr_pipe.sv
// base_rotr_pipe: pipelined runtime-amount rotator, one registered mux level per amount bit.
// Define BASE_ROTR_PIPE_LEFT_EN to add the i_dir port and per-word left rotation.
module base_rotr_pipe #(
    parameter int width = 8
) (
    input  logic            clk,
    input  logic            reset,
    base_rotr_pipe_if.slave bus
);

    localparam int aw   = (width > 1) ? $clog2(width) : 1;
    localparam int nlev = aw;

    logic [nlev-1:0]  v_q;
    logic [nlev-1:0]  v_d;
    logic [nlev-1:0]  rdy;
    logic [0:width-1] d_q   [nlev];
    logic [0:width-1] d_d   [nlev];
    logic [0:width-1] lvl   [nlev];
    logic [aw-1:0]    amt_q [nlev];
    logic [aw-1:0]    amt_d [nlev];
`ifdef BASE_ROTR_PIPE_LEFT_EN
    logic [nlev-1:0]  dir_q;
    logic [nlev-1:0]  dir_d;
`endif

    // Right rotate on a [0:width-1] word: bit j moves to (j+s)%width.
    function automatic logic [0:width-1] rot_r(
        input logic [0:width-1] x,
        input int               s
    );
        logic [0:width-1] y;
        y = x;
        for (int j = 0; j < width; j++) begin
            y[(j + s) % width] = x[j];
        end
        return y;
    endfunction

    // Level k sits after stage k's register and uses amount bit k.
    always_comb begin
        for (int k = 0; k < nlev; k++) begin
            lvl[k] = d_q[k];
            if (amt_q[k][k]) begin
`ifdef BASE_ROTR_PIPE_LEFT_EN
                if (dir_q[k]) begin
                    lvl[k] = rot_r(d_q[k],
                        (width - ((1 << k) % width)) % width);
                end else begin
                    lvl[k] = rot_r(d_q[k], (1 << k) % width);
                end
`else
                lvl[k] = rot_r(d_q[k], (1 << k) % width);
`endif
            end
        end
    end

    // Stage k may load when it or any stage below the output is empty.
    always_comb begin
        for (int k = 0; k < nlev; k++) begin
            rdy[k] = bus.o_r;
            for (int m = k; m < nlev; m++) begin
                if (!v_q[m]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < nlev; k++) begin
            d_d[k]   = d_q[k];
            amt_d[k] = amt_q[k];
        end
`ifdef BASE_ROTR_PIPE_LEFT_EN
        dir_d = dir_q;
`endif
        if (rdy[0]) begin
            v_d[0] = bus.i_v;
            if (bus.i_v) begin
                d_d[0]   = bus.i_d;
                amt_d[0] = bus.i_amt;
`ifdef BASE_ROTR_PIPE_LEFT_EN
                dir_d[0] = bus.i_dir;
`endif
            end
        end
        for (int k = 1; k < nlev; k++) begin
            if (rdy[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    d_d[k]   = lvl[k-1];
                    amt_d[k] = amt_q[k-1];
`ifdef BASE_ROTR_PIPE_LEFT_EN
                    dir_d[k] = dir_q[k-1];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < nlev; k++) begin
                d_q[k]   <= '0;
                amt_q[k] <= '0;
            end
`ifdef BASE_ROTR_PIPE_LEFT_EN
            dir_q <= '0;
`endif
        end else begin
            v_q <= v_d;
            for (int k = 0; k < nlev; k++) begin
                d_q[k]   <= d_d[k];
                amt_q[k] <= amt_d[k];
            end
`ifdef BASE_ROTR_PIPE_LEFT_EN
            dir_q <= dir_d;
`endif
        end
    end

    assign bus.i_r = rdy[0];
    assign bus.o_v = v_q[nlev-1];
    assign bus.o_d = lvl[nlev-1];

endmodule

// File: tb/tb_base_rotr_pipe.sv
// tb_base_rotr_pipe: directed bench for base_rotr_pipe at width 8 and width 6.
// Scoreboard model plus literal expectations; BASE_ROTR_PIPE_LEFT_EN adds a left test.
module tb_base_rotr_pipe;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   out8;

    base_rotr_pipe_if #(.width(8)) bus8 ();
    base_rotr_pipe_if #(.width(6)) bus6 ();

    base_rotr_pipe #(.width(8)) u8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    base_rotr_pipe #(.width(6)) u6 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:7] q8 [$];
    logic [0:5] q6 [$];

    function automatic logic [0:7] mdl8(
        input logic [0:7] d, input int amt, input bit left);
        logic [0:7] y;
        int r;
        r = amt % 8;
        for (int j = 0; j < 8; j++) begin
            if (left) y[j] = d[(j + r) % 8];
            else      y[(j + r) % 8] = d[j];
        end
        return y;
    endfunction

    function automatic logic [0:5] mdl6(input logic [0:5] d, input int amt);
        logic [0:5] y;
        int r;
        r = amt % 6;
        for (int j = 0; j < 6; j++) y[(j + r) % 6] = d[j];
        return y;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid output is checked against the oldest accepted word.
    always @(negedge clk) begin
        bit dir8;
        if (reset) begin
            q8.delete();
            q6.delete();
        end else begin
`ifdef BASE_ROTR_PIPE_LEFT_EN
            dir8 = bus8.i_dir;
`else
            dir8 = 1'b0;
`endif
            if (bus8.o_v) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL u8_spurious o_v=1 with no word outstanding");
                end else if (bus8.o_d !== q8[0]) begin
                    errors++;
                    $display("FAIL u8_data got %b expected %b", bus8.o_d, q8[0]);
                end
                if (bus8.o_r) begin
                    out8++;
                    if (q8.size() != 0) void'(q8.pop_front());
                end
            end
            if (bus8.i_v && bus8.i_r)
                q8.push_back(mdl8(bus8.i_d, int'(bus8.i_amt), dir8));
            if (bus6.o_v) begin
                checks++;
                if (q6.size() == 0) begin
                    errors++;
                    $display("FAIL u6_spurious o_v=1 with no word outstanding");
                end else if (bus6.o_d !== q6[0]) begin
                    errors++;
                    $display("FAIL u6_data got %b expected %b", bus6.o_d, q6[0]);
                end
                if (bus6.o_r && q6.size() != 0) void'(q6.pop_front());
            end
            if (bus6.i_v && bus6.i_r)
                q6.push_back(mdl6(bus6.i_d, int'(bus6.i_amt)));
        end
    end

    logic [7:0] lit8 [8];
    logic [5:0] lit6 [4];
    logic [2:0] amt6 [4];
    logic [0:7] wd [5];
    logic [2:0] wa [5];

    initial begin
        int w;
        int base;
        bit acc;
        checks = 0;
        errors = 0;
        out8   = 0;
        lit8 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        lit6 = '{6'b011000, 6'b110000, 6'b100001, 6'b000011};
        amt6 = '{3'd7, 3'd6, 3'd5, 3'd4};
        wd   = '{8'hC0, 8'hA5, 8'h3C, 8'h81, 8'h0F};
        wa   = '{3'd2, 3'd1, 3'd5, 3'd7, 3'd4};
        reset = 1'b1;
        bus8.i_v = 1'b0; bus8.i_d = '0; bus8.i_amt = '0; bus8.o_r = 1'b1;
        bus6.i_v = 1'b0; bus6.i_d = '0; bus6.i_amt = '0; bus6.o_r = 1'b1;
`ifdef BASE_ROTR_PIPE_LEFT_EN
        bus8.i_dir = 1'b0;
        bus6.i_dir = 1'b0;
`endif

        // Reset state during and right after a two-cycle reset
        step;
        @(negedge clk);
        chk("rst_ov", bus8.o_v, 0);
        chk("rst_od", bus8.o_d, 0);
        chk("rst_ir", bus8.i_r, 1);
        chk("rst6_od", bus6.o_d, 0);
        step;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ov", bus8.o_v, 0);
        chk("post_rst_od", bus8.o_d, 0);
        chk("post_rst_ir", bus8.i_r, 1);
        chk("post_rst6_ir", bus6.i_r, 1);
        step;

        // Back-to-back amounts 0..7, latency 3, one word per cycle
        for (int t = 0; t < 12; t++) begin
            if (t < 8) begin
                bus8.i_v = 1'b1; bus8.i_d = 8'h80; bus8.i_amt = 3'(t);
            end else begin
                bus8.i_v = 1'b0;
            end
            @(negedge clk);
            if (t < 3 || t >= 11) begin
                chk("seq_idle_ov", bus8.o_v, 0);
            end else begin
                chk("seq_ov", bus8.o_v, 1);
                chk("seq_od", bus8.o_d, lit8[t-3]);
            end
            if (t < 8) chk("seq_ir", bus8.i_r, 1);
            step;
        end

        // Width 6: amounts at or above width wrap modulo 6
        for (int t = 0; t < 8; t++) begin
            if (t < 4) begin
                bus6.i_v = 1'b1; bus6.i_d = 6'b110000; bus6.i_amt = amt6[t];
            end else begin
                bus6.i_v = 1'b0;
            end
            @(negedge clk);
            if (t >= 3 && t < 7) begin
                chk("w6_ov", bus6.o_v, 1);
                chk("w6_od", bus6.o_d, lit6[t-3]);
            end else begin
                chk("w6_idle_ov", bus6.o_v, 0);
            end
            step;
        end

        // Backpressure: three words fill the pipe, output holds the first
        base = out8;
        bus8.o_r = 1'b0;
        w = 0;
        for (int t = 0; t < 6; t++) begin
            bus8.i_v = 1'b1; bus8.i_d = wd[w]; bus8.i_amt = wa[w];
            @(negedge clk);
            acc = bus8.i_r;
            chk("bp_ir", acc, (t < 3) ? 1 : 0);
            if (t >= 3) begin
                chk("bp_ov", bus8.o_v, 1);
                chk("bp_hold_od", bus8.o_d, 8'h30);
            end
            step;
            if (acc) w++;
        end
        chk("bp_accepted", w, 3);
        bus8.o_r = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (w == 5 && q8.size() == 0) break;
            if (w < 5) begin
                bus8.i_v = 1'b1; bus8.i_d = wd[w]; bus8.i_amt = wa[w];
            end else begin
                bus8.i_v = 1'b0;
            end
            @(negedge clk);
            acc = bus8.i_v && bus8.i_r;
            step;
            if (acc) w++;
        end
        bus8.i_v = 1'b0;
        chk("bp_all_sent", w, 5);
        chk("bp_out_count", out8 - base, 5);
        chk("bp_drained", q8.size(), 0);

        // Reset with two words in flight flushes them
        for (int t = 0; t < 2; t++) begin
            bus8.i_v = 1'b1; bus8.i_d = 8'hF0; bus8.i_amt = 3'(t + 1);
            step;
        end
        bus8.i_v = 1'b0;
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("flush_ov", bus8.o_v, 0);
            chk("flush_ir", bus8.i_r, 1);
            step;
        end
        for (int t = 0; t < 5; t++) begin
            if (t == 0) begin
                bus8.i_v = 1'b1; bus8.i_d = 8'h01; bus8.i_amt = 3'd3;
            end else begin
                bus8.i_v = 1'b0;
            end
            @(negedge clk);
            if (t == 3) begin
                chk("after_flush_ov", bus8.o_v, 1);
                chk("after_flush_od", bus8.o_d, 8'h20);
            end else begin
                chk("after_flush_idle", bus8.o_v, 0);
            end
            step;
        end

`ifdef BASE_ROTR_PIPE_LEFT_EN
        // Left versus right by one on the same word
        for (int t = 0; t < 6; t++) begin
            if (t < 2) begin
                bus8.i_v = 1'b1; bus8.i_d = 8'h01; bus8.i_amt = 3'd1;
                bus8.i_dir = (t == 0);
            end else begin
                bus8.i_v = 1'b0;
            end
            @(negedge clk);
            if (t == 3) chk("left_od", bus8.o_d, 8'h02);
            if (t == 4) chk("right_od", bus8.o_d, 8'h80);
            step;
        end
        bus8.i_dir = 1'b0;
`endif

        step;
        step;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not reach its end");
        $fatal(1);
    end

endmodule
